// File: rtl/clip_ctrl_pkg.sv
// clip_ctrl_pkg
// Shared types and defaults for the clip record/playback controller.
//   state_t          : one-hot controller state (S_IDLE, S_RECORD, S_PLAY)
//   DEF_NUM_CLIPS    : default number of clip slots
//   DEF_CLIP_SAMPLES : default samples per clip (2 s at 8 kHz)
package clip_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_RECORD = 3'b010,
        S_PLAY   = 3'b100
    } state_t;

    localparam int DEF_NUM_CLIPS    = 4;
    localparam int DEF_CLIP_SAMPLES = 16000;

endpackage

// File: rtl/clip_sample_counter.sv
// clip_sample_counter
// Sample index within the active clip. Advances on each tick while enabled and
// wraps to 0 after the last sample. clear has priority over counting.
//   clock, reset : system clock, synchronous active-high reset
//   tick         : one-cycle sample strobe
//   clear        : force count to 0 on the next edge
//   enable       : count ticks
//   count        : current sample index
//   terminal     : tick on the last sample of the clip
module clip_sample_counter #(
    parameter int CLIP_SAMPLES = 16000,
    parameter int SAMPLE_W     = $clog2(CLIP_SAMPLES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                clear,
    input  logic                enable,
    output logic [SAMPLE_W-1:0] count,
    output logic                terminal
);

    localparam logic [SAMPLE_W-1:0] LAST = SAMPLE_W'(CLIP_SAMPLES - 1);

    assign terminal = tick && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && tick) begin
            count <= terminal ? '0 : count + SAMPLE_W'(1);
        end
    end

endmodule

// File: rtl/clip_record_controller.sv
// clip_record_controller
// Sequences record and playback of NUM_CLIPS clip slots in a shared sample
// memory and tracks which slots hold a complete recording.
//   clock, reset          : system clock, synchronous active-high reset
//   record, play, stop    : level requests / abort
//   clip_sel              : target slot, sampled when an operation starts
//   sample_tick           : one-cycle strobe per audio sample
//   mem_clip, mem_addr    : active slot and sample index (0 in IDLE)
//   mem_we                : memory write strobe (recording)
//   deseriena, seriena    : deserializer (record) / serializer (play) enables
//   busy                  : not IDLE
//   done                  : one-cycle pulse on normal completion
//   err_empty             : one-cycle pulse on play of an unrecorded slot
//   clip_valid            : per-slot "recording present" flags
//   loop                  : (CLIP_LOOP_PLAY_EN only) repeat playback until stop
// Build option: define CLIP_LOOP_PLAY_EN to add the loop input.
//
// state    | meaning
// S_IDLE   | waiting for record/play; counter held at 0
// S_RECORD | writing cur_clip, one sample per tick
// S_PLAY   | reading cur_clip, one sample per tick
module clip_record_controller
    import clip_ctrl_pkg::*;
#(
    parameter int NUM_CLIPS    = DEF_NUM_CLIPS,
    parameter int CLIP_SAMPLES = DEF_CLIP_SAMPLES,
    parameter int CLIP_W       = $clog2(NUM_CLIPS),
    parameter int SAMPLE_W     = $clog2(CLIP_SAMPLES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 record,
    input  logic                 play,
    input  logic                 stop,
`ifdef CLIP_LOOP_PLAY_EN
    input  logic                 loop,
`endif
    input  logic [CLIP_W-1:0]    clip_sel,
    input  logic                 sample_tick,
    output logic [CLIP_W-1:0]    mem_clip,
    output logic [SAMPLE_W-1:0]  mem_addr,
    output logic                 mem_we,
    output logic                 deseriena,
    output logic                 seriena,
    output logic                 busy,
    output logic                 done,
    output logic                 err_empty,
    output logic [NUM_CLIPS-1:0] clip_valid
);

    state_t                state_q, state_d;
    logic [CLIP_W-1:0]     cur_clip_q, cur_clip_d;
    logic [NUM_CLIPS-1:0]  valid_d;
    logic                  done_d, err_d;
    logic                  cnt_clear, terminal;
    logic [SAMPLE_W-1:0]   count;

    clip_sample_counter #(
        .CLIP_SAMPLES (CLIP_SAMPLES),
        .SAMPLE_W     (SAMPLE_W)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .tick     (sample_tick),
        .clear    (cnt_clear),
        .enable   (busy),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_clip_q <= '0;
            clip_valid <= '0;
            done       <= 1'b0;
            err_empty  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_clip_q <= cur_clip_d;
            clip_valid <= valid_d;
            done       <= done_d;
            err_empty  <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_clip_d = cur_clip_q;
        valid_d    = clip_valid;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_clear  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clear = 1'b1;
                if (record) begin
                    // Old contents are gone as soon as a new recording starts.
                    cur_clip_d        = clip_sel;
                    valid_d[clip_sel] = 1'b0;
                    state_d           = S_RECORD;
                end else if (play) begin
                    if (clip_valid[clip_sel]) begin
                        cur_clip_d = clip_sel;
                        state_d    = S_PLAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECORD: begin
                if (stop) begin
                    cnt_clear = 1'b1;
                    state_d   = S_IDLE;
                end else if (terminal) begin
                    valid_d[cur_clip_q] = 1'b1;
                    done_d              = 1'b1;
                    state_d             = S_IDLE;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    cnt_clear = 1'b1;
                    state_d   = S_IDLE;
                end else if (terminal) begin
                    done_d = 1'b1;
`ifdef CLIP_LOOP_PLAY_EN
                    if (!loop) state_d = S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                cnt_clear = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign deseriena = (state_q == S_RECORD);
    assign seriena   = (state_q == S_PLAY);
    assign mem_we    = deseriena && sample_tick;
    assign mem_clip  = busy ? cur_clip_q : '0;
    assign mem_addr  = busy ? count : '0;

endmodule

// File: tb/tb_clip_record_controller.sv
module tb_clip_record_controller;

    localparam int NC = 4;
    localparam int CS = 8;

    logic       clock = 1'b0;
    logic       reset, record, play, stop, sample_tick;
    logic       loop;
    logic [1:0] clip_sel;
    logic [1:0] mem_clip;
    logic [2:0] mem_addr;
    logic       mem_we, deseriena, seriena, busy, done, err_empty;
    logic [3:0] clip_valid;

    int vectors = 0;
    int miscompares = 0;

    clip_record_controller #(.NUM_CLIPS(NC), .CLIP_SAMPLES(CS)) dut (
        .clock       (clock),
        .reset       (reset),
        .record      (record),
        .play        (play),
        .stop        (stop),
`ifdef CLIP_LOOP_PLAY_EN
        .loop        (loop),
`endif
        .clip_sel    (clip_sel),
        .sample_tick (sample_tick),
        .mem_clip    (mem_clip),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .deseriena   (deseriena),
        .seriena     (seriena),
        .busy        (busy),
        .done        (done),
        .err_empty   (err_empty),
        .clip_valid  (clip_valid)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n ticks spaced by 'gap' idle cycles, checking address, write strobe, no early done
    task automatic run_ticks(input int first, input int n, input int gap, input logic exp_we);
        for (int k = first; k < first + n; k++) begin
            repeat (gap) step();
            sample_tick = 1'b1;
            #1;
            chk("tick_addr", mem_addr, k);
            chk("tick_we", mem_we, exp_we);
            chk("tick_done_low", done, 0);
            step();
            sample_tick = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; record = 1'b0; play = 1'b0; stop = 1'b0;
        sample_tick = 1'b0; loop = 1'b0; clip_sel = 2'd0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", clip_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_empty, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_clip", mem_clip, 0);
        chk("rst_we", mem_we, 0);
        reset = 1'b0;
        step();

        // full record of slot 2
        record = 1'b1; clip_sel = 2'd2;
        step();
        record = 1'b0; clip_sel = 2'd0;
        #1;
        chk("rec_deser", deseriena, 1);
        chk("rec_busy", busy, 1);
        chk("rec_clip", mem_clip, 2);
        chk("rec_addr0", mem_addr, 0);
        run_ticks(0, 8, 2, 1'b1);
        chk("rec_done", done, 1);
        chk("rec_valid", clip_valid, 4'b0100);
        chk("rec_busy_fall", busy, 0);
        chk("rec_deser_fall", deseriena, 0);
        step();
        chk("rec_done_pulse", done, 0);

        // play of empty slot 1
        play = 1'b1; clip_sel = 2'd1;
        step();
        play = 1'b0;
        #1;
        chk("empty_err", err_empty, 1);
        chk("empty_busy", busy, 0);
        chk("empty_ser", seriena, 0);
        step();
        chk("empty_err_pulse", err_empty, 0);

        // play slot 2
        play = 1'b1; clip_sel = 2'd2;
        step();
        play = 1'b0;
        #1;
        chk("play_ser", seriena, 1);
        chk("play_clip", mem_clip, 2);
        run_ticks(0, 8, 1, 1'b0);
        chk("play_done", done, 1);
        chk("play_ser_fall", seriena, 0);
        chk("play_valid", clip_valid, 4'b0100);
        step();
        chk("play_done_pulse", done, 0);

        // record slot 2 then stop after 3 ticks
        record = 1'b1; clip_sel = 2'd2;
        step();
        record = 1'b0;
        #1;
        chk("rerec_valid_clr", clip_valid, 4'b0000);
        run_ticks(0, 3, 1, 1'b1);
        chk("pre_stop_addr", mem_addr, 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        #1;
        chk("stop_busy", busy, 0);
        chk("stop_addr", mem_addr, 0);
        chk("stop_done", done, 0);
        step();
        chk("stop_done2", done, 0);
        chk("stop_valid", clip_valid, 4'b0000);

        // record slot 0 fully, then play it with stop on the last tick
        record = 1'b1; clip_sel = 2'd0;
        step();
        record = 1'b0;
        run_ticks(0, 8, 0, 1'b1);
        chk("rec0_valid", clip_valid, 4'b0001);
        chk("rec0_done", done, 1);
        step();
        play = 1'b1; clip_sel = 2'd0;
        step();
        play = 1'b0;
        run_ticks(0, 7, 0, 1'b0);
        stop = 1'b1; sample_tick = 1'b1;
        #1;
        chk("stopterm_addr", mem_addr, 7);
        step();
        stop = 1'b0; sample_tick = 1'b0;
        #1;
        chk("stopterm_done", done, 0);
        chk("stopterm_busy", busy, 0);
        chk("stopterm_valid", clip_valid, 4'b0001);

        // record has priority over play; reset mid-record
        step();
        record = 1'b1; play = 1'b1; clip_sel = 2'd3;
        step();
        record = 1'b0; play = 1'b0;
        #1;
        chk("prio_deser", deseriena, 1);
        chk("prio_ser", seriena, 0);
        chk("prio_clip", mem_clip, 3);
        run_ticks(0, 2, 0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", clip_valid, 0);
        chk("midrst_addr", mem_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
